// File: rtl/time_adjust_sequencer.sv
// Turns the four clock-setting buttons into one-cycle adjust commands with hold-to-repeat.
// Optional repeat acceleration is compiled in with `define ADJUST_ACCEL_EN.
module time_adjust_sequencer #(
    parameter int unsigned HOLD_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000,
    parameter int unsigned TIMER_W       = 26,
    parameter int unsigned ACCEL_COUNT   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       btn_min_up,
    input  logic       btn_min_dn,
    input  logic       btn_hr_up,
    input  logic       btn_hr_dn,
    output logic [2:0] adjust_code,
    output logic       busy
);

    localparam int unsigned NBTN   = 4;
    localparam int unsigned CODE_W = 3;

    // Compare values are "period minus one" because the timer is cleared on the pulse edge.
    localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(HOLD_DELAY - 1);
    localparam logic [TIMER_W-1:0] REP_LAST   = TIMER_W'(REPEAT_PERIOD - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

`ifdef ADJUST_ACCEL_EN
    // Fast interval is floored at 2 so pulses can never land on adjacent cycles.
    localparam int unsigned FAST_RAW    = REPEAT_PERIOD / 4;
    localparam int unsigned FAST_PERIOD = (FAST_RAW < 2) ? 2 : FAST_RAW;
    localparam logic [TIMER_W-1:0] FAST_LAST = TIMER_W'(FAST_PERIOD - 1);
    localparam int unsigned ACC_W = $clog2(ACCEL_COUNT + 1);
    localparam logic [ACC_W-1:0] ACC_LIMIT = ACC_W'(ACCEL_COUNT);
`endif

    if ((HOLD_DELAY < 2) || (REPEAT_PERIOD < 4) || (ACCEL_COUNT < 1) ||
        ((64'(1) << TIMER_W) <= 64'(HOLD_DELAY)) ||
        ((64'(1) << TIMER_W) <= 64'(REPEAT_PERIOD))) begin : g_param_check
        $error("time_adjust_sequencer: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_REPEAT,
        S_LOCKOUT
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d, timer_inc, rep_last;
    logic [NBTN-1:0]    latched_q, latched_d;
    logic [NBTN-1:0]    btn;
    logic [CODE_W-1:0]  code_d;
    logic               btn_one_c, btn_multi_c, other_high_c, held_c;
`ifdef ADJUST_ACCEL_EN
    logic [ACC_W-1:0]   acc_q, acc_d;
`endif

    assign btn = {btn_hr_dn, btn_hr_up, btn_min_dn, btn_min_up};

    function automatic logic [CODE_W-1:0] code_of(input logic [NBTN-1:0] onehot);
        logic [CODE_W-1:0] c;
        c = '0;
        for (int i = 0; i < NBTN; i++) begin
            if (onehot[i]) c = CODE_W'(i + 1);
        end
        return c;
    endfunction

    // Next-state, timer and command decode.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        latched_d    = latched_q;
        code_d       = '0;
        rep_last     = REP_LAST;
        timer_inc    = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_W'(1);
        btn_one_c    = (btn != '0) && ((btn & (btn - NBTN'(1))) == '0);
        btn_multi_c  = (btn != '0) && !btn_one_c;
        other_high_c = |(btn & ~latched_q);
        held_c       = |(btn & latched_q);
`ifdef ADJUST_ACCEL_EN
        acc_d        = acc_q;
        if (acc_q >= ACC_LIMIT) rep_last = FAST_LAST;
`endif

        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (btn_one_c) begin
                        code_d    = code_of(btn);
                        latched_d = btn;
                        timer_d   = '0;
                        state_d   = S_HOLD;
                    end else if (btn_multi_c) begin
                        state_d = S_LOCKOUT;
                    end
                end
                S_HOLD, S_REPEAT: begin
                    // A contender aborts before a release is considered.
                    if (other_high_c) begin
                        state_d = S_LOCKOUT;
                    end else if (!held_c) begin
                        state_d = S_IDLE;
                    end else if (timer_q == ((state_q == S_HOLD) ? HOLD_LAST : rep_last)) begin
                        code_d  = code_of(latched_q);
                        timer_d = '0;
                        state_d = S_REPEAT;
`ifdef ADJUST_ACCEL_EN
                        if (state_q == S_REPEAT && acc_q < ACC_LIMIT) acc_d = acc_q + ACC_W'(1);
`endif
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                S_LOCKOUT: begin
                    if (btn == '0) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (state_d == S_IDLE || state_d == S_LOCKOUT) begin
            latched_d = '0;
            timer_d   = '0;
        end
`ifdef ADJUST_ACCEL_EN
        if (state_d != S_REPEAT) acc_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            latched_q   <= '0;
            adjust_code <= '0;
            busy        <= 1'b0;
`ifdef ADJUST_ACCEL_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            latched_q   <= latched_d;
            adjust_code <= code_d;
            busy        <= (state_d != S_IDLE);
`ifdef ADJUST_ACCEL_EN
            acc_q       <= acc_d;
`endif
        end
    end

endmodule
